// File: rtl/seg_scan_reader_if.sv
// Pin-side bundle of the 7-segment scan reader: sampled display lines in,
// recovered frame value and status out.
interface seg_scan_reader_if #(
  parameter int DIGITS = 4
);
  logic [7:0]          seg_in;
  logic [DIGITS-1:0]   dig_in;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_out;
  logic                valid;
  logic                err;

  modport master (
    output seg_in, dig_in,
    input  value, dp_out, valid, err
  );

  modport slave (
    input  seg_in, dig_in,
    output value, dp_out, valid, err
  );
endinterface

// File: rtl/seg_scan_reader.sv
// Recovers the hex value shown on a multiplexed active-low 7-segment display
// and publishes one value per completed scan frame.
module seg_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_reader_if.slave bus
);

  localparam int         SW       = 8 + DIGITS;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_e;

  // Returns {recognised, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = {1'b1, 4'h0};
      7'h79:   seg_decode = {1'b1, 4'h1};
      7'h24:   seg_decode = {1'b1, 4'h2};
      7'h30:   seg_decode = {1'b1, 4'h3};
      7'h19:   seg_decode = {1'b1, 4'h4};
      7'h12:   seg_decode = {1'b1, 4'h5};
      7'h02:   seg_decode = {1'b1, 4'h6};
      7'h78:   seg_decode = {1'b1, 4'h7};
      7'h00:   seg_decode = {1'b1, 4'h8};
      7'h10:   seg_decode = {1'b1, 4'h9};
      7'h08:   seg_decode = {1'b1, 4'hA};
      7'h03:   seg_decode = {1'b1, 4'hB};
      7'h46:   seg_decode = {1'b1, 4'hC};
      7'h21:   seg_decode = {1'b1, 4'hD};
      7'h06:   seg_decode = {1'b1, 4'hE};
      7'h0E:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  logic [SW-1:0]       sync1_q, sync2_q;
  logic [7:0]          cnt_q, cnt_d;
  state_e              state_q, state_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                frame_err_q, frame_err_d;
  logic [4*DIGITS-1:0] shadow_nib_q, shadow_nib_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic [7:0]          seg_s;
  logic [DIGITS-1:0]   sel_s;
  logic [DIGITS-1:0]   cap_mask_s;
  logic [4:0]          dec_s;
  logic                s_chg_s, stable_s, one_sel_s, capture_s, publish_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= {bus.seg_in, bus.dig_in};
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  // sync1_q is what S becomes on the next edge, so a mismatch marks a change of S there.
  always_comb begin
    seg_s   = sync2_q[SW-1:DIGITS];
    sel_s   = ~sync2_q[DIGITS-1:0];
    s_chg_s = (sync1_q != sync2_q);
    if (s_chg_s) begin
      cnt_d = 8'd1;
    end else if (cnt_q < STABLE_C) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    stable_s  = (cnt_d == STABLE_C) && (cnt_q != STABLE_C);
    one_sel_s = (sel_s != '0) && ((sel_s & (sel_s - DIGITS'(1))) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SETTLE: begin
        if (stable_s && one_sel_s) state_d = HOLD;
        else                       state_d = SETTLE;
      end
      HOLD: begin
        if (s_chg_s) state_d = SETTLE;
        else         state_d = HOLD;
      end
      default: state_d = SETTLE;
    endcase
  end

  always_comb begin
    capture_s = 1'b0;
    case (state_q)
      SETTLE:  capture_s = stable_s && one_sel_s;
      HOLD:    capture_s = 1'b0;
      default: capture_s = 1'b0;
    endcase
  end

  // A capture on the publish edge lands in the freshly cleared frame.
  always_comb begin
    dec_s        = seg_decode(seg_s[6:0]);
    publish_s    = &mask_q;
    cap_mask_s   = capture_s ? sel_s : '0;
    mask_d       = (publish_s ? '0 : mask_q) | cap_mask_s;
    frame_err_d  = (publish_s ? 1'b0 : frame_err_q) | (capture_s & ~dec_s[4]);
    shadow_nib_d = shadow_nib_q;
    shadow_dp_d  = shadow_dp_q;
    for (int i = 0; i < DIGITS; i++) begin
      shadow_nib_d[4*i +: 4] = cap_mask_s[i] ? dec_s[3:0] : shadow_nib_q[4*i +: 4];
      shadow_dp_d[i]         = cap_mask_s[i] ? ~seg_s[7] : shadow_dp_q[i];
    end
    value_d = publish_s ? shadow_nib_q : value_q;
    dp_d    = publish_s ? shadow_dp_q : dp_q;
    err_d   = publish_s ? frame_err_q : err_q;
    valid_d = publish_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q       <= '0;
      frame_err_q  <= 1'b0;
      shadow_nib_q <= '0;
      shadow_dp_q  <= '0;
      value_q      <= '0;
      dp_q         <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      frame_err_q  <= frame_err_d;
      shadow_nib_q <= shadow_nib_d;
      shadow_dp_q  <= shadow_dp_d;
      value_q      <= value_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign bus.value  = value_q;
  assign bus.dp_out = dp_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: directed scans plus random scan steps, checked
// against a frame-level model of capture and publish rules.
module tb_seg_scan_reader;
  localparam int         DIGITS    = 4;
  localparam int         STABLE    = 4;
  localparam logic [7:0] BLANK_SEG = 8'hFF;
  localparam logic [3:0] NO_DIG    = 4'hF;

  typedef struct {
    int unsigned at_cyc;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        err;
  } pub_t;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  seg_scan_reader_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] seg_map [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Frame-level model state.
  pub_t        exp_q [$];
  logic [3:0]  m_nib  [DIGITS];
  logic        m_dp   [DIGITS];
  bit          m_have [DIGITS];
  bit          m_err;
  logic [15:0] last_value;
  logic [3:0]  last_dp;
  logic        last_err;
  logic [7:0]  cur_seg;
  logic [3:0]  cur_dig;
  bit          run_valid;
  bit          run_done;
  int unsigned run_start;

  function automatic logic [3:0] dig_sel(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < DIGITS; i++) begin
      m_nib[i]  = 4'h0;
      m_dp[i]   = 1'b0;
      m_have[i] = 1'b0;
    end
    m_err      = 1'b0;
    last_value = 16'h0000;
    last_dp    = 4'h0;
    last_err   = 1'b0;
    run_valid  = 1'b0;
    run_done   = 1'b0;
    run_start  = 0;
  endtask

  // Holds one pin pattern for n clocks, predicting captures/publishes and checking every cycle.
  task automatic drive_step(input logic [7:0] seg, input logic [3:0] dig, input int n);
    int          zeros;
    int          idx;
    int unsigned k0;
    bit          ok;
    bit          full;
    bit          exp_v;
    logic [3:0]  nib;
    pub_t        p;
    bus.seg_in = seg;
    bus.dig_in = dig;
    k0 = cyc + 1;
    if (!run_valid || seg !== cur_seg || dig !== cur_dig) begin
      run_valid = 1'b1;
      run_done  = 1'b0;
      run_start = k0;
      cur_seg   = seg;
      cur_dig   = dig;
    end
    zeros = 0;
    idx   = 0;
    for (int i = 0; i < DIGITS; i++) if (!dig[i]) begin zeros++; idx = i; end
    if (!run_done && zeros == 1 && (k0 + n - run_start) >= STABLE) begin
      run_done = 1'b1;
      ok  = 1'b0;
      nib = 4'h0;
      for (int v = 0; v < 16; v++) if (seg[6:0] == seg_map[v]) begin ok = 1'b1; nib = 4'(v); end
      m_nib[idx]  = nib;
      m_dp[idx]   = ~seg[7];
      m_have[idx] = 1'b1;
      m_err       = m_err | !ok;
      full = 1'b1;
      for (int i = 0; i < DIGITS; i++) if (!m_have[i]) full = 1'b0;
      if (full) begin
        p.at_cyc = run_start + STABLE + 1;
        for (int i = 0; i < DIGITS; i++) begin
          p.value[4*i +: 4] = m_nib[i];
          p.dp[i]           = m_dp[i];
          m_have[i]         = 1'b0;
        end
        p.err = m_err;
        m_err = 1'b0;
        exp_q.push_back(p);
      end
    end
    repeat (n) begin
      @(negedge clk);
      exp_v = (exp_q.size() > 0) && (exp_q[0].at_cyc == cyc);
      checks++;
      if (bus.valid !== exp_v) begin
        errors++;
        $display("FAIL valid cyc=%0d got=%b expected=%b", cyc, bus.valid, exp_v);
      end
      checks++;
      if (exp_v) begin
        if (bus.value !== exp_q[0].value || bus.dp_out !== exp_q[0].dp || bus.err !== exp_q[0].err) begin
          errors++;
          $display("FAIL publish cyc=%0d got value=%h dp=%b err=%b expected value=%h dp=%b err=%b",
                   cyc, bus.value, bus.dp_out, bus.err, exp_q[0].value, exp_q[0].dp, exp_q[0].err);
        end
        last_value = exp_q[0].value;
        last_dp    = exp_q[0].dp;
        last_err   = exp_q[0].err;
        void'(exp_q.pop_front());
      end else if (bus.value !== last_value || bus.dp_out !== last_dp || bus.err !== last_err) begin
        errors++;
        $display("FAIL hold cyc=%0d got value=%h dp=%b err=%b expected value=%h dp=%b err=%b",
                 cyc, bus.value, bus.dp_out, bus.err, last_value, last_dp, last_err);
      end
      if (exp_q.size() > 0 && exp_q[0].at_cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_publish cyc=%0d expected valid at cyc=%0d", cyc, exp_q[0].at_cyc);
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    drive_step(BLANK_SEG, NO_DIG, n);
  endtask

  task automatic scan_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3, input int n);
    drive_step(s0, dig_sel(0), n);
    drive_step(s1, dig_sel(1), n);
    drive_step(s2, dig_sel(2), n);
    drive_step(s3, dig_sel(3), n);
  endtask

  task automatic check_out(input string name, input logic [15:0] v, input logic [3:0] dp, input logic e);
    checks++;
    if (bus.value !== v || bus.dp_out !== dp || bus.err !== e) begin
      errors++;
      $display("FAIL %s got value=%h dp=%b err=%b expected value=%h dp=%b err=%b",
               name, bus.value, bus.dp_out, bus.err, v, dp, e);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n      = 1'b0;
    bus.seg_in = BLANK_SEG;
    bus.dig_in = NO_DIG;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.valid !== 1'b0 || bus.value !== 16'h0000 || bus.dp_out !== 4'h0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset got valid=%b value=%h dp=%b err=%b expected all zero",
               bus.valid, bus.value, bus.dp_out, bus.err);
    end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    scan_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 10);
    idle(10);
    check_out("basic", 16'h4321, 4'b0000, 1'b0);
  endtask

  task automatic test_dp();
    scan_frame(8'hF9, 8'hA4, 8'h46, 8'h99, 10);
    idle(10);
    check_out("dp", 16'h4C21, 4'b0100, 1'b0);
  endtask

  task automatic test_bad_pattern();
    scan_frame(8'hF9, 8'hFF, 8'hB0, 8'h99, 10);
    idle(10);
    check_out("bad_pattern", 16'h4301, 4'b0000, 1'b1);
    scan_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 10);
    idle(10);
    check_out("bad_then_clean", 16'h4321, 4'b0000, 1'b0);
  endtask

  task automatic test_short_hold();
    drive_step(8'h80, dig_sel(0), STABLE - 1);
    drive_step(8'hA4, dig_sel(1), 10);
    drive_step(8'hB0, dig_sel(2), 10);
    drive_step(8'h99, dig_sel(3), 10);
    idle(10);
    check_out("short_no_publish", 16'h4321, 4'b0000, 1'b0);
    drive_step(8'h80, dig_sel(0), 10);
    idle(10);
    check_out("short_rescan", 16'h4328, 4'b0000, 1'b0);
  endtask

  task automatic test_blanking();
    drive_step(8'hC0, dig_sel(0), 10);
    drive_step(8'hF9, dig_sel(1), 10);
    drive_step(8'hA4, dig_sel(2), 10);
    drive_step(8'h80, 4'b1111, 20);
    drive_step(8'hC0, 4'b1100, 20);
    drive_step(8'hB0, dig_sel(3), 50);
    idle(10);
    check_out("blank_keeps_mask", 16'h3210, 4'b0000, 1'b0);
    drive_step(8'hF9, dig_sel(0), 10);
    drive_step(8'hA4, dig_sel(1), 10);
    drive_step(8'hB0, dig_sel(2), 10);
    idle(10);
    check_out("long_hold_single_capture", 16'h3210, 4'b0000, 1'b0);
    drive_step(8'h99, dig_sel(3), 10);
    idle(10);
    check_out("blank_frame_done", 16'h4321, 4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    drive_step(8'h46, dig_sel(0), 10);
    drive_step(8'hA4, dig_sel(1), 10);
    drive_step(8'hB0, dig_sel(2), 10);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.value !== 16'h0000 || bus.dp_out !== 4'h0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got valid=%b value=%h dp=%b err=%b expected all zero",
               bus.valid, bus.value, bus.dp_out, bus.err);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_step(8'h99, dig_sel(3), 10);
    idle(10);
    check_out("partial_after_reset", 16'h0000, 4'b0000, 1'b0);
    scan_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 10);
    idle(10);
    check_out("rescan_after_reset", 16'h4321, 4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] dig;
    logic [6:0] seg7;
    logic [7:0] seg;
    int         k;
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 9) < 7) dig = dig_sel(int'($urandom_range(0, 3)));
      else                           dig = 4'($urandom_range(0, 15));
      k = int'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 8) seg7 = seg_map[k];
      else                           seg7 = 7'($urandom_range(0, 127));
      seg = {1'($urandom_range(0, 1)), seg7};
      drive_step(seg, dig, int'($urandom_range(1, 12)));
    end
    idle(12);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dp();
    test_bad_pattern();
    test_short_hold();
    test_blanking();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
